// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam int unsigned ENTRY_PC_W = 32;

  // One buffered fetch result as it travels from memory to decode.
  typedef struct packed {
    logic [31:0]           instr;
    logic [ENTRY_PC_W-1:0] pc;
  } fetch_entry_t;

  // Fetch sequencer states.
  localparam logic [1:0] FETCH      = 2'd0;
  localparam logic [1:0] WAIT_SPACE = 2'd1;
  localparam logic [1:0] DISCARD    = 2'd2;

  localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch FIFO holding {instruction, pc} words between memory and decode.
module fetch_fifo #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;

  // Pointer advance; clear empties the FIFO regardless of push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Overflow (push on full without a pop) and underflow must never happen.
  always_ff @(posedge clk) begin
    if (!rst && !clear) begin
      assert (!(push && full && !pop));
      assert (!(pop && empty));
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC generation, imem handshake, prefetch and IF/ID register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     bus      = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     PC_STEP  = 1,
  parameter logic [bus-1:0]  RESET_PC = '0
) (
  input  logic           clk,
  input  logic           rst,
  output logic           imem_req,
  output logic [bus-1:0] imem_addr,
  input  logic           imem_ack,
  input  logic [31:0]    imem_rdata,
  input  logic           redirect,
  input  logic [bus-1:0] redirect_pc,
  input  logic           stall,
  output logic           instr_valid,
  output logic [31:0]    instruction,
  output logic [bus-1:0] pc_out
);

  localparam int unsigned    EW     = 32 + bus;
  localparam logic [bus-1:0] PC_INC = bus'(PC_STEP);

  logic [1:0]     state_q, state_d;
  logic [bus-1:0] fetch_pc_q, fetch_pc_d;
  logic [bus-1:0] pend_pc_q, pend_pc_d;
  logic           out_valid_q, out_valid_d;
  logic [31:0]    out_instr_q, out_instr_d;
  logic [bus-1:0] out_pc_q, out_pc_d;

  logic           out_load, pop, push, accept, bypass;
  logic           f_full, f_empty;
  logic [EW-1:0]  f_rdata;

  // Per-cycle handshake, pop/push and bypass decisions.
  always_comb begin
    out_load = !out_valid_q || !stall;
    pop      = out_load && !f_empty && !redirect;
    case (state_q)
      FETCH:   imem_req = (!f_full || pop) && !rst;
      DISCARD: imem_req = !rst;
      default: imem_req = 1'b0;
    endcase
    accept = imem_req && imem_ack && (state_q != DISCARD) && !redirect;
    bypass = accept && out_load && f_empty;
    push   = accept && !bypass;
  end

  // Fetch PC sequencing and FSM; a redirect always takes priority.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    if (redirect) begin
      if (state_q == DISCARD) begin
        if (imem_ack) begin
          state_d    = FETCH;
          fetch_pc_d = redirect_pc;
        end else begin
          pend_pc_d = redirect_pc;
        end
      end else if (imem_req && !imem_ack) begin
        // Request in flight: keep it stable until its ack, then jump.
        state_d   = DISCARD;
        pend_pc_d = redirect_pc;
      end else begin
        state_d    = FETCH;
        fetch_pc_d = redirect_pc;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (accept) fetch_pc_d = fetch_pc_q + PC_INC;
          if (f_full && !pop) state_d = WAIT_SPACE;
        end
        WAIT_SPACE: if (pop) state_d = FETCH;
        DISCARD: begin
          if (imem_ack) begin
            state_d    = FETCH;
            fetch_pc_d = pend_pc_q;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // IF/ID register: load FIFO head, else the bypassed ack word, else go idle.
  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    if (redirect) begin
      out_valid_d = 1'b0;
    end else if (out_load) begin
      if (!f_empty) begin
        out_valid_d = 1'b1;
        out_instr_d = f_rdata[EW-1:bus];
        out_pc_d    = f_rdata[bus-1:0];
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_instr_d = imem_rdata;
        out_pc_d    = fetch_pc_q;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH;
      fetch_pc_q  <= RESET_PC;
      pend_pc_q   <= RESET_PC;
      out_valid_q <= 1'b0;
      out_instr_q <= NOP_INSTR;
      out_pc_q    <= RESET_PC;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      pend_pc_q   <= pend_pc_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

  fetch_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (redirect),
    .wdata ({imem_rdata, fetch_pc_q}),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (f_empty)
  );

  assign imem_addr   = fetch_pc_q;
  assign instr_valid = out_valid_q;
  assign instruction = out_instr_q;
  assign pc_out      = out_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed corner cases, a vector table and a random run.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        redirect = 1'b0, stall = 1'b0, instr_valid;
  logic [31:0] redirect_pc = '0, instruction, pc_out;

  always #5 clk = ~clk;

  fetch_unit #(.bus(32), .DEPTH(4), .PC_STEP(1), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .stall(stall), .instr_valid(instr_valid),
    .instruction(instruction), .pc_out(pc_out)
  );

  int vectors = 0;
  int errors  = 0;

  // Memory model
  int latency  = 0;
  bit rand_ack = 1'b0;
  int wait_cnt = 0;

  // Reference: the decoder must see consecutive PCs from the last redirect target.
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] last_pc = 32'h0;
  int          n_consumed = 0;
  bit          wrap_chk_en = 1'b0, wrap_next = 1'b0;

  bit          prev_req = 0, prev_ack = 0, prev_valid = 0, prev_stall = 0, prev_redir = 0;
  logic [31:0] prev_addr = '0, prev_pc = '0, prev_instr = '0;

  typedef struct {
    logic [31:0] target;
    int          count;
    logic [31:0] last_pc;
  } vec_t;
  vec_t tbl [4];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, answer the handshake, check, advance.
  task automatic step(input bit s, input bit r, input logic [31:0] rpc);
    bit ack_now;
    stall = s; redirect = r; redirect_pc = rpc;
    #1;
    ack_now = imem_req && (rand_ack ? ($urandom_range(1, 0) == 1) : (wait_cnt >= latency));
    imem_ack   = ack_now;
    imem_rdata = ack_now ? mem_word(imem_addr) : ~mem_word(imem_addr);
    #1;
    if (prev_req && !prev_ack) begin
      check("req_held", {31'b0, imem_req}, 32'h1);
      check("addr_stable", imem_addr, prev_addr);
    end
    if (prev_redir) begin
      check("redirect_squash", {31'b0, instr_valid}, 32'h0);
    end else if (prev_valid && prev_stall) begin
      check("stall_valid", {31'b0, instr_valid}, 32'h1);
      check("stall_pc", pc_out, prev_pc);
      check("stall_instr", instruction, prev_instr);
    end
    if (wrap_next && imem_req) begin
      check("addr_wrap", imem_addr, 32'h0);
      wrap_next = 1'b0;
    end
    if (wrap_chk_en && imem_req && imem_ack && !r && imem_addr == 32'hFFFF_FFFF) wrap_next = 1'b1;
    if (instr_valid && !s && !r) begin
      $display("consume pc=%h instr=%h", pc_out, instruction);
      check("pc_seq", pc_out, exp_pc);
      check("instr_word", instruction, mem_word(exp_pc));
      last_pc = pc_out;
      exp_pc  = exp_pc + 32'h1;
      n_consumed++;
    end
    if (r) exp_pc = rpc;
    prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
    prev_valid = instr_valid; prev_stall = s; prev_redir = r;
    prev_pc = pc_out; prev_instr = instruction;
    @(posedge clk);
    if (prev_req && prev_ack) wait_cnt = 0;
    else if (prev_req) wait_cnt++;
    @(negedge clk);
  endtask

  task automatic run_until_valid(input logic [31:0] pc, input int budget, input string name);
    int n = 0;
    while (!(instr_valid && pc_out == pc) && n < budget) begin
      step(1'b0, 1'b0, 32'h0);
      n++;
    end
    check(name, {31'b0, (instr_valid && pc_out == pc)}, 32'h1);
  endtask

  task automatic run_until_req(input logic [31:0] addr, input int budget, input string name);
    int n = 0;
    while (!(imem_req && imem_addr == addr) && n < budget) begin
      step(1'b0, 1'b0, 32'h0);
      n++;
    end
    check(name, {31'b0, (imem_req && imem_addr == addr)}, 32'h1);
  endtask

  initial begin
    tbl[0] = '{target: 32'hFFFF_FFFE, count: 4, last_pc: 32'h0000_0001};
    tbl[1] = '{target: 32'h0000_0100, count: 3, last_pc: 32'h0000_0102};
    tbl[2] = '{target: 32'h7FFF_FFFF, count: 2, last_pc: 32'h8000_0000};
    tbl[3] = '{target: 32'hFFFF_FFFF, count: 2, last_pc: 32'h0000_0000};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_instr", instruction, 32'h0);
    check("rst_pc", pc_out, 32'h0);
    rst = 1'b0;

    // Sequential fetch from reset with a zero-latency memory
    step(1'b0, 1'b0, 32'h0);
    check("first_valid", {31'b0, instr_valid}, 32'h1);
    check("first_pc", pc_out, 32'h0);
    repeat (4) step(1'b0, 1'b0, 32'h0);
    check("seq_last", last_pc, 32'h3);

    // Stall fills the FIFO, then drains back-to-back
    step(1'b0, 1'b1, 32'h10);
    run_until_valid(32'h10, 10, "reach_0x10");
    repeat (4) step(1'b1, 1'b0, 32'h0);
    check("full_req_low", {31'b0, imem_req}, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    check("frozen_pc", pc_out, 32'h10);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 32'h0);
      check("drain_valid", {31'b0, instr_valid}, 32'h1);
      check("drain_pc", pc_out, 32'h11 + 32'(i));
      if (i == 0) begin
        check("resume_req", {31'b0, imem_req}, 32'h1);
        check("resume_addr", imem_addr, 32'h15);
      end
    end

    // Redirect squashes a full FIFO holding 0x05..0x08
    step(1'b0, 1'b1, 32'h04);
    run_until_valid(32'h04, 10, "reach_0x04");
    repeat (5) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h40);
    check("squash_valid", {31'b0, instr_valid}, 32'h0);
    begin
      int n = 0;
      while (!instr_valid && n < 10) begin step(1'b0, 1'b0, 32'h0); n++; end
      check("first_after_redirect", pc_out, 32'h40);
    end

    // Redirect while a slow request is in flight
    latency = 3;
    step(1'b0, 1'b1, 32'h20);
    run_until_req(32'h20, 20, "req_0x20");
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h80);
    check("discard_addr", imem_addr, 32'h20);
    run_until_req(32'h80, 10, "req_0x80");

    // Redirect coinciding with an ack: no DISCARD cycle
    latency = 2;
    step(1'b0, 1'b1, 32'h30);
    run_until_req(32'h30, 20, "req_0x30");
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h90);
    check("same_cycle_req", {31'b0, imem_req}, 32'h1);
    check("same_cycle_addr", imem_addr, 32'h90);

    // Table of redirect targets, including address wrap
    latency = 0;
    wrap_chk_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int base;
      int n;
      step(1'b0, 1'b1, tbl[i].target);
      base = n_consumed;
      n = 0;
      while ((n_consumed - base) < tbl[i].count && n < 40) begin
        step(1'b0, 1'b0, 32'h0);
        n++;
      end
      check("tbl_count", 32'(n_consumed - base), 32'(tbl[i].count));
      check("tbl_last_pc", last_pc, tbl[i].last_pc);
    end
    wrap_chk_en = 1'b0;
    wrap_next   = 1'b0;

    // Asynchronous reset in the middle of a pending request
    latency = 3;
    step(1'b0, 1'b1, 32'h200);
    run_until_valid(32'h200, 20, "reach_0x200");
    step(1'b1, 1'b0, 32'h0);
    check("pre_rst_req", {31'b0, imem_req}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_req", {31'b0, imem_req}, 32'h0);
    check("async_rst_valid", {31'b0, instr_valid}, 32'h0);
    check("async_rst_pc", pc_out, 32'h0);
    check("async_rst_addr", imem_addr, 32'h0);
    @(negedge clk);
    imem_ack = 1'b0; stall = 1'b0; redirect = 1'b0;
    prev_req = 0; prev_ack = 0; prev_valid = 0; prev_stall = 0; prev_redir = 0;
    wait_cnt = 0; exp_pc = 32'h0;
    rst = 1'b0;
    run_until_valid(32'h0, 20, "post_rst_pc0");

    // Random traffic: random ack timing, stalls and redirects
    rand_ack = 1'b1;
    for (int i = 0; i < 600; i++) begin
      bit s, r;
      logic [31:0] t;
      s = ($urandom_range(9, 0) < 3);
      r = ($urandom_range(19, 0) == 0);
      t = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFD : $urandom;
      step(s, r, t);
    end
    rand_ack = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
